// File: rtl/eigen_result_serializer.sv
// eigen_result_serializer
// Captures one packed multi-byte result word from the eigen block and streams
// it out one byte per valid/ready transfer, byte 0 first. An optional XOR
// checksum trailer byte follows the data bytes. axiol flags the final byte of
// each frame.
module eigen_result_serializer #(
    parameter int NUM_BYTES = 13,
    parameter bit CSUM_EN   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BYTES-1:0][7:0] axiid,
    input  logic                      axiiv,
    output logic                      axiir,
    output logic [7:0]                axiod,
    output logic                      axiov,
    output logic                      axiol,
    input  logic                      axior
);

    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
    localparam bit LAST_IS_DATA0 = (CSUM_EN == 1'b0) && (NUM_BYTES == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    // Running XOR checksum step over one transmitted byte.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                    state_q, state_d;
    logic [NUM_BYTES-1:0][7:0] data_q, data_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [7:0]                csum_q, csum_d;
    logic [7:0]                axiod_q, axiod_d;
    logic                      axiov_q, axiov_d;
    logic                      axiol_q, axiol_d;

    logic                      capture_s;
    logic                      xfer_s;
    logic                      at_last_s;
    logic [CNT_W-1:0]          cnt_inc_s;
    logic [7:0]                cur_byte_s;

    assign axiir      = (state_q == ST_IDLE) && !rst;
    assign capture_s  = axiiv && axiir;
    assign xfer_s     = axiov_q && axior;
    assign at_last_s  = (cnt_q == LAST_IDX);
    assign cnt_inc_s  = cnt_q + CNT_W'(1);
    assign cur_byte_s = data_q[cnt_q];

    assign axiod = axiod_q;
    assign axiov = axiov_q;
    assign axiol = axiol_q;

    // State register: FSM state, shadow buffer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            csum_q  <= 8'h00;
            axiod_q <= 8'h00;
            axiov_q <= 1'b0;
            axiol_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            axiod_q <= axiod_d;
            axiov_q <= axiov_d;
            axiol_q <= axiol_d;
        end
    end

    // Next-state logic: capture, byte advance and checksum accumulation.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    data_d  = axiid;
                    cnt_d   = '0;
                    csum_d  = 8'h00;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    csum_d = csum_step(csum_q, cur_byte_s);
                    if (at_last_s) begin
                        state_d = (CSUM_EN == 1'b1) ? ST_CSUM : ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: next value of the registered byte stream; holds under backpressure.
    always_comb begin
        axiod_d = axiod_q;
        axiov_d = axiov_q;
        axiol_d = axiol_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    axiov_d = 1'b1;
                    axiod_d = axiid[0];
                    axiol_d = LAST_IS_DATA0;
                end else begin
                    axiov_d = 1'b0;
                    axiod_d = 8'h00;
                    axiol_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    if (at_last_s) begin
                        if (CSUM_EN == 1'b1) begin
                            axiov_d = 1'b1;
                            axiod_d = csum_step(csum_q, cur_byte_s);
                            axiol_d = 1'b1;
                        end else begin
                            axiov_d = 1'b0;
                            axiod_d = 8'h00;
                            axiol_d = 1'b0;
                        end
                    end else begin
                        axiov_d = 1'b1;
                        axiod_d = data_q[cnt_inc_s];
                        axiol_d = (CSUM_EN == 1'b0) && (cnt_inc_s == LAST_IDX);
                    end
                end else begin
                    axiov_d = axiov_q;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    axiov_d = 1'b0;
                    axiod_d = 8'h00;
                    axiol_d = 1'b0;
                end else begin
                    axiov_d = axiov_q;
                end
            end
            default: begin
                axiov_d = 1'b0;
                axiod_d = 8'h00;
                axiol_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_eigen_result_serializer.sv
// Self-checking bench for eigen_result_serializer: four instances cover
// 13 bytes with checksum, 4 bytes with checksum, 4 bytes without checksum and
// a single byte with checksum.
module tb_eigen_result_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Instance A: NUM_BYTES=13, CSUM_EN=1
    logic              a_rst, a_iv, a_ir, a_ov, a_ol, a_or;
    logic [12:0][7:0]  a_d;
    logic [7:0]        a_od;
    // Instance B: NUM_BYTES=4, CSUM_EN=1
    logic              rst_s;
    logic              b_iv, b_ir, b_ov, b_ol, b_or;
    logic [3:0][7:0]   b_d;
    logic [7:0]        b_od;
    // Instance C: NUM_BYTES=4, CSUM_EN=0
    logic              c_iv, c_ir, c_ov, c_ol, c_or;
    logic [3:0][7:0]   c_d;
    logic [7:0]        c_od;
    // Instance D: NUM_BYTES=1, CSUM_EN=1
    logic              d_iv, d_ir, d_ov, d_ol, d_or;
    logic [0:0][7:0]   d_d;
    logic [7:0]        d_od;

    eigen_result_serializer #(.NUM_BYTES(13), .CSUM_EN(1'b1)) u_a (
        .clk(clk), .rst(a_rst), .axiid(a_d), .axiiv(a_iv), .axiir(a_ir),
        .axiod(a_od), .axiov(a_ov), .axiol(a_ol), .axior(a_or));
    eigen_result_serializer #(.NUM_BYTES(4), .CSUM_EN(1'b1)) u_b (
        .clk(clk), .rst(rst_s), .axiid(b_d), .axiiv(b_iv), .axiir(b_ir),
        .axiod(b_od), .axiov(b_ov), .axiol(b_ol), .axior(b_or));
    eigen_result_serializer #(.NUM_BYTES(4), .CSUM_EN(1'b0)) u_c (
        .clk(clk), .rst(rst_s), .axiid(c_d), .axiiv(c_iv), .axiir(c_ir),
        .axiod(c_od), .axiov(c_ov), .axiol(c_ol), .axior(c_or));
    eigen_result_serializer #(.NUM_BYTES(1), .CSUM_EN(1'b1)) u_d (
        .clk(clk), .rst(rst_s), .axiid(d_d), .axiiv(d_iv), .axiir(d_ir),
        .axiod(d_od), .axiov(d_ov), .axiol(d_ol), .axior(d_or));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfers observed on instance A, as {last, byte}
    logic [8:0] a_q[$];
    logic       hold_pend = 1'b0;
    logic       hold_ol;
    logic [7:0] hold_od;

    // Records A's transfers and checks that a stalled byte holds steady.
    always @(negedge clk) begin
        if (a_ov && a_or) a_q.push_back({a_ol, a_od});
        if (hold_pend) chk("bp_hold", {23'd0, a_ov, a_ol, a_od}, {23'd0, 1'b1, hold_ol, hold_od});
        hold_pend <= a_ov && !a_or && !a_rst;
        hold_ol   <= a_ol;
        hold_od   <= a_od;
    end

    logic [5:0] bp_pat = 6'b101001;   // 1,0,0,1,0,1 from bit 0 upward

    // Sends one word to A, drives axior by mode (0 always, 1 pattern, 2 random)
    // and compares the observed frame with the bytes plus their XOR trailer.
    task automatic run_a(input logic [12:0][7:0] w, input int mode, input string tag);
        int guard;
        int cyc;
        logic [7:0] acc;
        a_q.delete();
        guard = 0;
        while (!a_ir && guard < 50) begin step(); guard++; end
        a_d  = w;
        a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        a_d  = ~w;
        chk({tag, "_first_valid"}, {31'd0, a_ov}, 32'd1);
        cyc = 0;
        while (a_q.size() < 14 && cyc < 300) begin
            if (mode == 0)      a_or = 1'b1;
            else if (mode == 1) a_or = bp_pat[cyc % 6];
            else                a_or = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        a_or = 1'b1;
        if (mode == 0) chk({tag, "_frame_cycles"}, cyc, 32'd14);
        chk({tag, "_ov_after"}, {31'd0, a_ov}, 32'd0);
        chk({tag, "_ir_after"}, {31'd0, a_ir}, 32'd1);
        chk({tag, "_len"}, a_q.size(), 32'd14);
        if (a_q.size() == 14) begin
            acc = 8'h00;
            for (int i = 0; i < 13; i++) begin
                chk({tag, "_byte"}, {23'd0, a_q[i]}, {23'd0, 1'b0, w[i]});
                acc = acc ^ w[i];
            end
            chk({tag, "_trailer"}, {23'd0, a_q[13]}, {23'd0, 1'b1, acc});
        end
    endtask

    typedef struct {
        logic [12:0][7:0] word;
        logic [7:0]       exp_csum;
        int               mode;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [12:0][7:0] w;
        logic [12:0][7:0] inc;
        logic [7:0] b_exp[5];
        logic [7:0] c_exp[8];
        int guard;

        for (int i = 0; i < 13; i++) inc[i] = 8'(i + 1);
        tbl[0].word = inc;               tbl[0].exp_csum = 8'h01; tbl[0].mode = 0;
        tbl[1].word = inc;               tbl[1].exp_csum = 8'h01; tbl[1].mode = 1;
        tbl[2].word = '0;                tbl[2].exp_csum = 8'h00; tbl[2].mode = 0;
        tbl[3].word = {13{8'hFF}};       tbl[3].exp_csum = 8'hFF; tbl[3].mode = 2;

        a_rst = 1'b1; a_iv = 1'b1; a_d = inc; a_or = 1'b1;
        rst_s = 1'b1;
        b_iv = 1'b0; b_d = '0; b_or = 1'b1;
        c_iv = 1'b0; c_d = '0; c_or = 1'b1;
        d_iv = 1'b0; d_d = '0; d_or = 1'b1;

        // Reset held 3 cycles with axiiv high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ir", {31'd0, a_ir}, 32'd0);
            chk("rst_ov", {31'd0, a_ov}, 32'd0);
            chk("rst_od", {24'd0, a_od}, 32'd0);
        end
        a_rst = 1'b0;
        rst_s = 1'b0;
        a_iv  = 1'b0;
        #1;
        chk("rel_ir", {31'd0, a_ir}, 32'd1);
        step();
        chk("rel_no_capture", {31'd0, a_ov}, 32'd0);

        // Table-driven frames on the 13-byte instance
        for (int t = 0; t < 4; t++) begin
            run_a(tbl[t].word, tbl[t].mode, "tbl");
            if (a_q.size() == 14) chk("tbl_csum_const", {24'd0, a_q[13][7:0]}, {24'd0, tbl[t].exp_csum});
        end

        // Randomized frames against the reference model
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 13; i++) w[i] = 8'($urandom_range(0, 255));
            run_a(w, $urandom_range(0, 2), "rnd");
        end

        // Mid-frame reset after the third byte
        a_q.delete();
        guard = 0;
        while (!a_ir && guard < 50) begin step(); guard++; end
        a_d = {13{8'h77}}; a_iv = 1'b1; a_or = 1'b1;
        step();
        a_iv = 1'b0;
        guard = 0;
        while (a_q.size() < 3 && guard < 50) begin step(); guard++; end
        a_rst = 1'b1; a_or = 1'b0;
        step();
        chk("abort_ov", {31'd0, a_ov}, 32'd0);
        chk("abort_ir", {31'd0, a_ir}, 32'd0);
        a_rst = 1'b0; a_or = 1'b1;
        step();
        step();
        chk("abort_no_more", a_q.size(), 32'd3);
        chk("abort_idle_ov", {31'd0, a_ov}, 32'd0);
        for (int i = 0; i < 13; i++) w[i] = 8'(8'h30 + i * 7);
        run_a(w, 0, "post_rst");

        // 4 bytes with checksum: 01,00,00,01 then 00 last
        b_exp = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
        b_d = {8'd1, 8'd0, 8'd0, 8'd1}; b_iv = 1'b1;
        step();
        b_iv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("b4_ov", {31'd0, b_ov}, 32'd1);
            chk("b4_od", {24'd0, b_od}, {24'd0, b_exp[k]});
            chk("b4_ol", {31'd0, b_ol}, (k == 4) ? 32'd1 : 32'd0);
            step();
        end
        chk("b4_done_ov", {31'd0, b_ov}, 32'd0);
        chk("b4_done_ir", {31'd0, b_ir}, 32'd1);

        // 4 bytes without checksum, second word back-to-back with axiiv held
        c_exp = '{8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h78, 8'h56, 8'h34, 8'h12};
        c_d = {8'hAA, 8'h55, 8'h0F, 8'hF0}; c_iv = 1'b1;
        step();
        c_d = {8'h12, 8'h34, 8'h56, 8'h78};
        for (int k = 0; k < 4; k++) begin
            chk("c1_ov", {31'd0, c_ov}, 32'd1);
            chk("c1_od", {24'd0, c_od}, {24'd0, c_exp[k]});
            chk("c1_ol", {31'd0, c_ol}, (k == 3) ? 32'd1 : 32'd0);
            chk("c1_ir_busy", {31'd0, c_ir}, 32'd0);
            step();
        end
        chk("c_gap_ov", {31'd0, c_ov}, 32'd0);
        chk("c_gap_ir", {31'd0, c_ir}, 32'd1);
        step();
        c_iv = 1'b0;
        for (int k = 4; k < 8; k++) begin
            chk("c2_ov", {31'd0, c_ov}, 32'd1);
            chk("c2_od", {24'd0, c_od}, {24'd0, c_exp[k]});
            chk("c2_ol", {31'd0, c_ol}, (k == 7) ? 32'd1 : 32'd0);
            step();
        end
        chk("c_done_ov", {31'd0, c_ov}, 32'd0);

        // Single-byte word: data byte then identical checksum
        d_d = 8'h5A; d_iv = 1'b1;
        step();
        d_iv = 1'b0;
        chk("d1_ov", {31'd0, d_ov}, 32'd1);
        chk("d1_od", {24'd0, d_od}, 32'h5A);
        chk("d1_ol", {31'd0, d_ol}, 32'd0);
        step();
        chk("d1_csum_od", {24'd0, d_od}, 32'h5A);
        chk("d1_csum_ol", {31'd0, d_ol}, 32'd1);
        step();
        chk("d1_done_ov", {31'd0, d_ov}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
